// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the 16:1 mux round-robin scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_sched_pkg;

    localparam int DEF_N_REQ    = 16;
    localparam int DEF_SEL_W    = $clog2(DEF_N_REQ);
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_HOLD_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GRANT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // One-hot vector with only bit 'idx' set.
    function automatic logic [DEF_N_REQ-1:0] onehot(input logic [DEF_SEL_W-1:0] idx);
        logic [DEF_N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request bit is set.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   valid  : at least one request set
//   winner : index of the selected request
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] winner
);

    // Walk offsets from farthest to nearest so the smallest offset from ptr
    // is the last assignment and therefore wins. N_REQ is a power of two, so
    // the SEL_W-bit add wraps naturally from N_REQ-1 back to 0.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                valid  = 1'b1;
                winner = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner of the 16:1 mux select/enable; sel settles a cycle around every enable pulse.
// Latency: req seen in IDLE at t -> gnt/sel at t+1, en at t+2; en held 1..MAX_HOLD cycles.
// Backpressure: requests are levels; a requester waits (not dropped) while busy, as long as req stays high.
//   clk, rst_n : clock, synchronous active-low reset
//   req, done  : per-requester request level and early release (done only honoured for the granted index in GRANT)
//   sel, en    : registered mux select and output enable
//   gnt, busy  : registered one-hot grant (zero outside SETUP/GRANT) and non-IDLE flag
// Optional build macro MUX_SCHED_PRIO_EN adds input prio: requests with prio set win over plain ones.
module mux16_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = DEF_HOLD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
`ifdef MUX_SCHED_PRIO_EN
    input  logic [N_REQ-1:0] prio,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold;

    logic              any_vld;
    logic [SEL_W-1:0]  any_win;
    logic              pick_vld;
    logic [SEL_W-1:0]  pick_win;

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick_all (
        .req    (req),
        .ptr    (ptr),
        .valid  (any_vld),
        .winner (any_win)
    );

`ifdef MUX_SCHED_PRIO_EN
    logic [N_REQ-1:0]  req_prio;
    logic              prio_vld;
    logic [SEL_W-1:0]  prio_win;

    assign req_prio = req & prio;

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick_prio (
        .req    (req_prio),
        .ptr    (ptr),
        .valid  (prio_vld),
        .winner (prio_win)
    );

    // Both classes share ptr; the prio class simply shadows the plain one.
    assign pick_vld = any_vld;
    assign pick_win = prio_vld ? prio_win : any_win;
`else
    assign pick_vld = any_vld;
    assign pick_win = any_win;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            en    <= 1'b0;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // sel only ever moves here, so it is stable for a full
                    // SETUP cycle before en and through the GAP cycle after.
                    if (pick_vld) begin
                        sel   <= pick_win;
                        gnt   <= onehot(pick_win);
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (!req[sel]) begin
                        // Requester withdrew before the pulse: abort without
                        // touching ptr so it keeps its turn.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        en    <= 1'b1;
                        hold  <= HOLD_W'(1);
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (done[sel] || !req[sel] || (hold == HOLD_W'(MAX_HOLD))) begin
                        en    <= 1'b0;
                        gnt   <= '0;
                        ptr   <= sel + SEL_W'(1);
                        state <= GAP;
                    end else begin
                        hold  <= hold + HOLD_W'(1);
                    end
                end
                GAP: begin
                    hold  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    en    <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
